jal_redirect_writeback: RTL and testbench

//  Stage directly downstream of the JAL ALU. Consumes its link value (pc+4) and jump target.

---
 rtl/jal_redirect_writeback_pkg.sv | 21 ++
 rtl/jal_redirect_writeback_if.sv | 34 +++
 rtl/jal_redirect_writeback_flush_counter.sv | 27 ++
 rtl/jal_redirect_writeback.sv | 133 +++++++++++++
 tb/tb_jal_redirect_writeback.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jal_redirect_writeback_pkg.sv
// Shared types and constants for the JAL redirect/writeback stage.
// State encodings, the x0 index and the default datapath width.
package jal_redirect_writeback_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WB       = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_TRAP     = 3'd4
  } state_e;

  // No compressed instructions, so any nonzero low pair is a misaligned target.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/jal_redirect_writeback_if.sv
// Handshake and data bus of the JAL redirect/writeback stage.
// The master modport is the stage itself; the slave modport is its environment.
interface jal_redirect_writeback_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd_addr;
  logic [XLEN-1:0] in_rd_value;
  logic [XLEN-1:0] in_next_pc;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            trap_valid;
  logic            trap_ready;
  logic [XLEN-1:0] trap_tval;
  logic            done;

  modport master (
    input  in_valid, in_rd_addr, in_rd_value, in_next_pc, redirect_ready, trap_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc,
           flush, trap_valid, trap_tval, done
  );

  modport slave (
    output in_valid, in_rd_addr, in_rd_value, in_next_pc, redirect_ready, trap_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc,
           flush, trap_valid, trap_tval, done
  );
endinterface

// File: rtl/jal_redirect_writeback_flush_counter.sv
// Down-counter timing the flush window: load, decrement, zero flag.
module jal_redirect_writeback_flush_counter #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);
  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
endmodule

// File: rtl/jal_redirect_writeback.sv
// JAL retirement: write link to rd, redirect fetch, hold flush, or trap on a misaligned target.
// state    | meaning
// IDLE     | ready for a JAL ALU result
// WB       | one-cycle link write (suppressed for x0)
// REDIRECT | fetch redirect held until accepted
// FLUSH    | wrong-path kill, FLUSH_CYCLES long
// TRAP     | misaligned-target trap held until accepted
module jal_redirect_writeback
  import jal_redirect_writeback_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input logic clock,
  input logic reset,
  jal_redirect_writeback_if.master bus
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(FLUSH_CYCLES - 1);

  state_e          r_state, w_state_nxt;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rd_value, r_target;
  logic            r_in_ready, r_rf_we, r_redirect_valid, r_flush, r_trap_valid, r_done;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata, r_redirect_pc, r_trap_tval;

  logic            w_accept, w_cnt_load, w_cnt_dec, w_cnt_zero, w_done_d;
  logic [CW-1:0]   w_count;
  logic [4:0]      w_rd_addr;
  logic [XLEN-1:0] w_rd_value, w_target;

  assign w_accept = bus.in_valid && r_in_ready;

  // Outputs are registered from the next state, so the accept cycle must see the live inputs.
  assign w_rd_addr  = w_accept ? bus.in_rd_addr  : r_rd_addr;
  assign w_rd_value = w_accept ? bus.in_rd_value : r_rd_value;
  assign w_target   = w_accept ? bus.in_next_pc  : r_target;

  jal_redirect_writeback_flush_counter #(.W(CW)) u_flush_counter (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_cnt_dec),
    .o_count    (w_count),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_done_d    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = is_misaligned(bus.in_next_pc[1:0]) ? ST_TRAP : ST_WB;
        end
      end
      ST_WB: w_state_nxt = ST_REDIRECT;
      ST_REDIRECT: begin
        if (bus.redirect_ready) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_load  = 1'b1;
          w_done_d    = (FLUSH_CYCLES == 1);
        end
      end
      ST_FLUSH: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
          w_done_d  = (w_count == CW'(1));
        end
      end
      ST_TRAP: begin
        if (bus.trap_ready) begin
          w_state_nxt = ST_IDLE;
          w_done_d    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_rd_addr        <= '0;
      r_rd_value       <= '0;
      r_target         <= '0;
      r_in_ready       <= 1'b1;
      r_rf_we          <= 1'b0;
      r_rf_waddr       <= '0;
      r_rf_wdata       <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_trap_valid     <= 1'b0;
      r_trap_tval      <= '0;
      r_done           <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rd_addr  <= bus.in_rd_addr;
        r_rd_value <= bus.in_rd_value;
        r_target   <= bus.in_next_pc;
      end
      r_in_ready       <= (w_state_nxt == ST_IDLE);
      r_rf_we          <= (w_state_nxt == ST_WB) && (w_rd_addr != REG_X0);
      r_rf_waddr       <= (w_state_nxt == ST_WB) ? w_rd_addr : '0;
      r_rf_wdata       <= (w_state_nxt == ST_WB) ? w_rd_value : '0;
      r_redirect_valid <= (w_state_nxt == ST_REDIRECT);
      r_redirect_pc    <= (w_state_nxt == ST_REDIRECT) ? r_target : '0;
      r_flush          <= (w_state_nxt == ST_FLUSH);
      r_trap_valid     <= (w_state_nxt == ST_TRAP);
      r_trap_tval      <= (w_state_nxt == ST_TRAP) ? w_target : '0;
      r_done           <= w_done_d;
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.rf_we          = r_rf_we;
  assign bus.rf_waddr       = r_rf_waddr;
  assign bus.rf_wdata       = r_rf_wdata;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.flush          = r_flush;
  assign bus.trap_valid     = r_trap_valid;
  assign bus.trap_tval      = r_trap_tval;
  assign bus.done           = r_done;
endmodule

// File: tb/tb_jal_redirect_writeback.sv
// Directed bench for jal_redirect_writeback: vector table plus hand-written stall/reset/back-to-back cases.
module tb_jal_redirect_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  jal_redirect_writeback_if #(.XLEN(32)) bus ();

  jal_redirect_writeback #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] tgt;
    bit          exp_trap;
    bit          exp_we;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
    chk({tag, "_rf_waddr"}, 32'(bus.rf_waddr), 32'd0);
    chk({tag, "_rf_wdata"}, bus.rf_wdata, 32'd0);
    chk({tag, "_redir_v"}, 32'(bus.redirect_valid), 32'd0);
    chk({tag, "_redir_pc"}, bus.redirect_pc, 32'd0);
    chk({tag, "_flush"}, 32'(bus.flush), 32'd0);
    chk({tag, "_trap_v"}, 32'(bus.trap_valid), 32'd0);
    chk({tag, "_tval"}, bus.trap_tval, 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  // One full JAL with both ready inputs tied high; checks every cycle until idle again.
  task automatic run_jal(input string tag, input vec_t v);
    chk({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_rd_addr  = v.rd;
    bus.in_rd_value = v.val;
    bus.in_next_pc  = v.tgt;
    tick();
    bus.in_valid = 1'b0;
    if (!v.exp_trap) begin
      chk({tag, "_wb_we"}, 32'(bus.rf_we), 32'(v.exp_we));
      if (v.exp_we) begin
        chk({tag, "_wb_addr"}, 32'(bus.rf_waddr), 32'(v.rd));
        chk({tag, "_wb_data"}, bus.rf_wdata, v.val);
      end
      chk({tag, "_wb_redir"}, 32'(bus.redirect_valid), 32'd0);
      chk({tag, "_wb_ready"}, 32'(bus.in_ready), 32'd0);
      tick();
      chk({tag, "_rd_v"}, 32'(bus.redirect_valid), 32'd1);
      chk({tag, "_rd_pc"}, bus.redirect_pc, v.tgt);
      chk({tag, "_rd_we"}, 32'(bus.rf_we), 32'd0);
      tick();
      chk({tag, "_fl1"}, 32'(bus.flush), 32'd1);
      chk({tag, "_fl1_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_fl1_redir"}, 32'(bus.redirect_valid), 32'd0);
      tick();
      chk({tag, "_fl2"}, 32'(bus.flush), 32'd1);
      chk({tag, "_fl2_done"}, 32'(bus.done), 32'd1);
      tick();
      chk({tag, "_end_flush"}, 32'(bus.flush), 32'd0);
      chk({tag, "_end_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_end_ready"}, 32'(bus.in_ready), 32'd1);
    end else begin
      chk({tag, "_trap_v"}, 32'(bus.trap_valid), 32'd1);
      chk({tag, "_trap_tval"}, bus.trap_tval, v.tgt);
      chk({tag, "_trap_we"}, 32'(bus.rf_we), 32'd0);
      chk({tag, "_trap_redir"}, 32'(bus.redirect_valid), 32'd0);
      tick();
      chk({tag, "_trap_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_trap_clr"}, 32'(bus.trap_valid), 32'd0);
      chk({tag, "_trap_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_trap_redir2"}, 32'(bus.redirect_valid), 32'd0);
      tick();
      chk({tag, "_trap_done_off"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{rd: 5'd5,  val: 32'h0000_0104, tgt: 32'h0000_0200, exp_trap: 1'b0, exp_we: 1'b1};
    vecs[1] = '{rd: 5'd0,  val: 32'h0000_0084, tgt: 32'h0000_0080, exp_trap: 1'b0, exp_we: 1'b0};
    vecs[2] = '{rd: 5'd31, val: 32'hFFFF_FFF8, tgt: 32'hFFFF_FFFC, exp_trap: 1'b0, exp_we: 1'b1};
    vecs[3] = '{rd: 5'd7,  val: 32'h0000_0010, tgt: 32'h0000_0202, exp_trap: 1'b1, exp_we: 1'b0};
    vecs[4] = '{rd: 5'd3,  val: 32'h0000_0020, tgt: 32'h0000_0201, exp_trap: 1'b1, exp_we: 1'b0};
    vecs[5] = '{rd: 5'd9,  val: 32'h0000_0030, tgt: 32'h8000_0003, exp_trap: 1'b1, exp_we: 1'b0};

    bus.in_valid       = 1'b0;
    bus.in_rd_addr     = '0;
    bus.in_rd_value    = '0;
    bus.in_next_pc     = '0;
    bus.redirect_ready = 1'b1;
    bus.trap_ready     = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk_reset_state("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_jal($sformatf("vec%0d", i), vecs[i]);
    end

    // Trap held with trap_ready low; a stray redirect_ready must not matter.
    bus.trap_ready     = 1'b0;
    bus.in_valid       = 1'b1;
    bus.in_rd_addr     = 5'd4;
    bus.in_rd_value    = 32'h0000_0050;
    bus.in_next_pc     = 32'h0000_0202;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tstall%0d_v", i), 32'(bus.trap_valid), 32'd1);
      chk($sformatf("tstall%0d_tval", i), bus.trap_tval, 32'h0000_0202);
      chk($sformatf("tstall%0d_done", i), 32'(bus.done), 32'd0);
      chk($sformatf("tstall%0d_we", i), 32'(bus.rf_we), 32'd0);
      tick();
    end
    chk("tstall_last_v", 32'(bus.trap_valid), 32'd1);
    bus.trap_ready = 1'b1;
    tick();
    chk("tstall_done", 32'(bus.done), 32'd1);
    chk("tstall_clr", 32'(bus.trap_valid), 32'd0);
    chk("tstall_redir", 32'(bus.redirect_valid), 32'd0);
    tick();

    // Redirect stall; a second JAL presented during the stall must be ignored.
    bus.redirect_ready = 1'b0;
    bus.trap_ready     = 1'b1;
    bus.in_valid       = 1'b1;
    bus.in_rd_addr     = 5'd2;
    bus.in_rd_value    = 32'h0000_0304;
    bus.in_next_pc     = 32'h0000_0300;
    tick();
    bus.in_rd_addr  = 5'd6;
    bus.in_rd_value = 32'h0000_0404;
    bus.in_next_pc  = 32'h0000_0400;
    chk("rstall_wb_addr", 32'(bus.rf_waddr), 32'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstall%0d_v", i), 32'(bus.redirect_valid), 32'd1);
      chk($sformatf("rstall%0d_pc", i), bus.redirect_pc, 32'h0000_0300);
      chk($sformatf("rstall%0d_flush", i), 32'(bus.flush), 32'd0);
      chk($sformatf("rstall%0d_ready", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("rstall%0d_we", i), 32'(bus.rf_we), 32'd0);
      tick();
    end
    bus.in_valid       = 1'b0;
    bus.redirect_ready = 1'b1;
    tick();
    chk("rstall_fl1", 32'(bus.flush), 32'd1);
    tick();
    chk("rstall_fl2_done", 32'(bus.done), 32'd1);
    tick();
    chk("rstall_idle", 32'(bus.in_ready), 32'd1);
    tick();
    chk("rstall_no_second_we", 32'(bus.rf_we), 32'd0);
    chk("rstall_no_second_trap", 32'(bus.trap_valid), 32'd0);

    // Reset during FLUSH.
    bus.in_valid    = 1'b1;
    bus.in_rd_addr  = 5'd8;
    bus.in_rd_value = 32'h0000_0504;
    bus.in_next_pc  = 32'h0000_0500;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("rstfl_in_flush", 32'(bus.flush), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_state("rst_flush");
    rst = 1'b0;
    tick();
    chk("rstfl_after_flush", 32'(bus.flush), 32'd0);
    chk("rstfl_after_done", 32'(bus.done), 32'd0);

    // Reset during REDIRECT.
    bus.redirect_ready = 1'b0;
    bus.in_valid       = 1'b1;
    bus.in_rd_addr     = 5'd12;
    bus.in_rd_value    = 32'h0000_0604;
    bus.in_next_pc     = 32'h0000_0600;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rstrd_in_redir", 32'(bus.redirect_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_state("rst_redir");
    rst = 1'b0;
    bus.redirect_ready = 1'b1;
    tick();
    chk("rstrd_after_flush", 32'(bus.flush), 32'd0);
    run_jal("post_reset", '{rd: 5'd13, val: 32'h0000_0704, tgt: 32'h0000_0700, exp_trap: 1'b0, exp_we: 1'b1});

    // Back-to-back with in_valid held high.
    bus.in_valid    = 1'b1;
    bus.in_rd_addr  = 5'd10;
    bus.in_rd_value = 32'h0000_1000;
    bus.in_next_pc  = 32'h0000_2000;
    tick();
    bus.in_rd_addr  = 5'd11;
    bus.in_rd_value = 32'h0000_3000;
    bus.in_next_pc  = 32'h0000_4000;
    chk("b2b_a_we", 32'(bus.rf_we), 32'd1);
    chk("b2b_a_addr", 32'(bus.rf_waddr), 32'd10);
    chk("b2b_a_data", bus.rf_wdata, 32'h0000_1000);
    tick();
    chk("b2b_a_pc", bus.redirect_pc, 32'h0000_2000);
    tick();
    chk("b2b_a_fl1", 32'(bus.flush), 32'd1);
    chk("b2b_a_fl1_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("b2b_a_done", 32'(bus.done), 32'd1);
    tick();
    chk("b2b_ready_back", 32'(bus.in_ready), 32'd1);
    chk("b2b_gap_we", 32'(bus.rf_we), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_b_we", 32'(bus.rf_we), 32'd1);
    chk("b2b_b_addr", 32'(bus.rf_waddr), 32'd11);
    chk("b2b_b_data", bus.rf_wdata, 32'h0000_3000);
    tick();
    chk("b2b_b_pc", bus.redirect_pc, 32'h0000_4000);
    tick();
    chk("b2b_b_fl1", 32'(bus.flush), 32'd1);
    tick();
    chk("b2b_b_done", 32'(bus.done), 32'd1);
    tick();
    chk("b2b_b_idle", 32'(bus.in_ready), 32'd1);
    tick();
    chk("b2b_no_third", 32'(bus.rf_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
